// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for the bit-serial adder: operands and start from the
// requester, busy/done status and the registered {cout,sum} result back.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder built from one half-adder used twice per bit, LSB first.
// Latency: done in the cycle after edge k+2*WIDTH; start while busy is ignored.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, HA1, HA2, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             c1;
    logic             s1;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    // The one shared half-adder: operand bits in HA1, partial sum + carry in HA2.
    logic ha_x, ha_y, ha_s, ha_c;
    always_comb begin
        ha_x = (state == HA2) ? s1    : a_q[0];
        ha_y = (state == HA2) ? carry : b_q[0];
        ha_s = ha_x ^ ha_y;
        ha_c = ha_x & ha_y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            c1     <= 1'b0;
            s1     <= 1'b0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        carry  <= 1'b0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= HA1;
                    end
                end
                HA1: begin
                    s1    <= ha_s;
                    c1    <= ha_c;
                    state <= HA2;
                end
                HA2: begin
                    // Operands shift down so the current bit is always at [0].
                    sum_q <= sum_q | (WIDTH'(ha_s) << idx);
                    carry <= c1 | ha_c;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    if (idx == IW'(WIDTH - 1)) begin
                        cout_q <= c1 | ha_c;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= HA1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised checks of serial_add_ctrl at WIDTH = 8, 1 and 13.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Slot 0: WIDTH=8, slot 1: WIDTH=1, slot 2: WIDTH=13
    logic        start_v [3];
    logic [31:0] a_v     [3];
    logic [31:0] b_v     [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic [32:0] res_o   [3];

    int tests = 0;
    int fails = 0;

    serial_add_ctrl_if #(.WIDTH(8))  if8 ();
    serial_add_ctrl_if #(.WIDTH(1))  if1 ();
    serial_add_ctrl_if #(.WIDTH(13)) if13 ();

    serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_add_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    serial_add_ctrl #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(if13.slave));

    assign if8.start  = start_v[0];
    assign if8.a      = a_v[0][7:0];
    assign if8.b      = b_v[0][7:0];
    assign if1.start  = start_v[1];
    assign if1.a      = a_v[1][0:0];
    assign if1.b      = b_v[1][0:0];
    assign if13.start = start_v[2];
    assign if13.a     = a_v[2][12:0];
    assign if13.b     = b_v[2][12:0];

    assign busy_o[0] = if8.busy;
    assign busy_o[1] = if1.busy;
    assign busy_o[2] = if13.busy;
    assign done_o[0] = if8.done;
    assign done_o[1] = if1.done;
    assign done_o[2] = if13.done;
    assign res_o[0]  = 33'({if8.cout, if8.sum});
    assign res_o[1]  = 33'({if1.cout, if1.sum});
    assign res_o[2]  = 33'({if13.cout, if13.sum});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wof(input int s);
        return (s == 0) ? 8 : (s == 1) ? 1 : 13;
    endfunction

    // One complete add: checks clear-on-start, latency, busy span, result,
    // single-cycle done and result hold in the following IDLE cycle.
    task automatic add_op(input int s, input logic [31:0] x, input logic [31:0] y);
        int          w;
        int          cyc;
        int          nbusy;
        logic [32:0] m;
        logic [32:0] exp;
        w   = wof(s);
        m   = (33'd1 << w) - 33'd1;
        exp = ({1'b0, x} & m) + ({1'b0, y} & m);
        @(negedge clk);
        a_v[s] = x;
        b_v[s] = y;
        start_v[s] = 1'b1;
        @(posedge clk);
        #1;
        start_v[s] = 1'b0;
        chk("clear_on_start", res_o[s], 0);
        cyc   = 0;
        nbusy = int'(busy_o[s]);
        while (!done_o[s] && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            nbusy += int'(busy_o[s]);
        end
        chk("latency", cyc, 2 * w);
        chk("busy_span", nbusy, 2 * w + 1);
        chk("result", res_o[s], exp);
        @(posedge clk);
        #1;
        chk("done_single", {busy_o[s], done_o[s]}, 2'b00);
        chk("hold", res_o[s], exp);
    endtask

    initial begin
        int t;
        int last;
        int n;
        int ndone;
        for (int s = 0; s < 3; s++) begin
            start_v[s] = 1'b0;
            a_v[s] = '0;
            b_v[s] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("rst_busy", busy_o[s], 0);
            chk("rst_done", done_o[s], 0);
            chk("rst_res", res_o[s], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        add_op(0, 32'h0F, 32'h01);
        add_op(0, 32'hFF, 32'h01);
        add_op(0, 32'hFF, 32'hFF);
        add_op(0, 32'h00, 32'h00);

        // start held high; operands scrambled whenever the block is busy
        @(negedge clk);
        a_v[0] = 32'h55;
        b_v[0] = 32'hAA;
        start_v[0] = 1'b1;
        t = 0;
        last = 0;
        n = 0;
        while (n < 3 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
            if (busy_o[0]) begin
                a_v[0] = $urandom;
                b_v[0] = $urandom;
            end else begin
                a_v[0] = 32'h55;
                b_v[0] = 32'hAA;
            end
            if (done_o[0]) begin
                chk("held_result", res_o[0], 33'h0FF);
                if (n > 0) chk("held_period", t - last, 18);
                last = t;
                n++;
                if (n == 3) start_v[0] = 1'b0;
            end
        end
        start_v[0] = 1'b0;
        chk("held_count", n, 3);
        repeat (2) @(posedge clk);

        // reset in the middle of an add; start during reset must be ignored
        @(negedge clk);
        a_v[0] = 32'h12;
        b_v[0] = 32'h34;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy_o[0], 0);
        chk("abort_done", done_o[0], 0);
        chk("abort_res", res_o[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_v[0] = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            ndone += int'(done_o[0]) + int'(busy_o[0]);
        end
        chk("abort_quiet", ndone, 0);
        add_op(0, 32'h80, 32'h80);

        add_op(1, 32'h0, 32'h0);
        add_op(1, 32'h0, 32'h1);
        add_op(1, 32'h1, 32'h0);
        add_op(1, 32'h1, 32'h1);

        add_op(2, 32'h1FFF, 32'h0001);
        add_op(2, 32'h0AAA, 32'h1555);

        fork
            for (int i = 0; i < 1000; i++) add_op(0, $urandom, $urandom);
            for (int i = 0; i < 1000; i++) add_op(2, $urandom, $urandom);
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
